alu_writeback: RTL and testbench

- Execute/writeback stage directly downstream of the 16-bit ALU.
- Registers each ALU output bundle (ALU_Result, Remainder, Overflow_flag) with its opcode and destination, and drives the single register-file write port.
- Multiply and divide take two write cycles: the result goes to Rd, then the remainder or high product goes to a dedicated remainder register.
- Handles the HALT opcode, overflow, and illegal opcodes, and keeps a retired-instruction counter.

---
 rtl/alu_writeback.sv | 119 +++++++++++
 tb/tb_alu_writeback.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_writeback.sv
// Execute/writeback stage behind the 16-bit ALU: registers each ALU bundle and drives the register-file write port.
// Optional build macro OVERFLOW_TRAP_EN: an overflowing add/sub/mul traps (no writes, exc=1, halt) instead of writing.
module alu_writeback #(
  parameter int WIDTH   = 16,
  parameter int REM_REG = 15,
  parameter int ADDR_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        CTRL,
  input  logic [WIDTH-1:0]  ALU_Result,
  input  logic [WIDTH-1:0]  Remainder,
  input  logic              Overflow_flag,
  input  logic [ADDR_W-1:0] dest_reg,
  input  logic              reg_write,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata,
  output logic              halted,
  output logic              exc,
  output logic              ovf_sticky,
  output logic              illegal_op,
  output logic [15:0]       retired
);

  typedef enum logic [1:0] {S_RUN, S_REM, S_HALT} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_rem;
  logic              r_rf_we;
  logic [ADDR_W-1:0] r_rf_waddr;
  logic [WIDTH-1:0]  r_rf_wdata;
  logic              r_halted;
  logic              r_ovf_sticky;
  logic              r_illegal;
  logic [15:0]       r_retired;
  logic              w_ovf_op;
  logic              w_muldiv;

  // Overflow only means something for add, sub and mul.
  assign w_ovf_op = Overflow_flag && (CTRL == 4'd0 || CTRL == 4'd1 || CTRL == 4'd4);
  assign w_muldiv = (CTRL == 4'd4) || (CTRL == 4'd5);
  assign in_ready = (r_state == S_RUN);

`ifdef OVERFLOW_TRAP_EN
  logic r_exc;
  assign exc = r_exc;
`else
  assign exc = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_RUN;
      r_rem        <= '0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_halted     <= 1'b0;
      r_ovf_sticky <= 1'b0;
      r_illegal    <= 1'b0;
      r_retired    <= '0;
`ifdef OVERFLOW_TRAP_EN
      r_exc        <= 1'b0;
`endif
    end else begin
      r_rf_we   <= 1'b0;
      r_illegal <= 1'b0;
      case (r_state)
        S_RUN: begin
          if (in_valid) begin
            r_retired <= r_retired + 16'd1;
            if (w_ovf_op) r_ovf_sticky <= 1'b1;
`ifdef OVERFLOW_TRAP_EN
            if (w_ovf_op) begin
              r_exc    <= 1'b1;
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else
`endif
            if (CTRL == 4'd10) begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end else if (CTRL >= 4'd11) begin
              r_illegal <= 1'b1;
            end else if (reg_write) begin
              r_rf_we    <= 1'b1;
              r_rf_waddr <= dest_reg;
              r_rf_wdata <= ALU_Result;
              if (w_muldiv) begin
                r_rem   <= Remainder;
                r_state <= S_REM;
              end
            end
          end
        end
        S_REM: begin
          // Second write of mul/div; lands after the Rd write, so it wins if Rd is REM_REG.
          r_rf_we    <= 1'b1;
          r_rf_waddr <= ADDR_W'(REM_REG);
          r_rf_wdata <= r_rem;
          r_state    <= S_RUN;
        end
        default: ;
      endcase
    end
  end

  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign halted     = r_halted;
  assign ovf_sticky = r_ovf_sticky;
  assign illegal_op = r_illegal;
  assign retired    = r_retired;

endmodule

// File: tb/tb_alu_writeback.sv
// Bench for alu_writeback: vector table plus hand sequences; register-file writes go through a scoreboard queue.
module tb_alu_writeback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  CTRL = '0;
  logic [15:0] ALU_Result = '0;
  logic [15:0] Remainder = '0;
  logic        Overflow_flag = 1'b0;
  logic [3:0]  dest_reg = '0;
  logic        reg_write = 1'b0;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        halted;
  logic        exc;
  logic        ovf_sticky;
  logic        illegal_op;
  logic [15:0] retired;

  alu_writeback dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .CTRL(CTRL), .ALU_Result(ALU_Result), .Remainder(Remainder),
    .Overflow_flag(Overflow_flag), .dest_reg(dest_reg), .reg_write(reg_write),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .halted(halted), .exc(exc), .ovf_sticky(ovf_sticky),
    .illegal_op(illegal_op), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  ctrl;
    logic [15:0] res;
    logic [15:0] rem;
    logic        ovf;
    logic [3:0]  dest;
    logic        rw;
    int          n_wr;
    logic [15:0] d1;
    logic [15:0] d2;
    logic        ill;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] sb[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          we_cnt = 0;
  int          ill_cnt = 0;
  int          exp_ret = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] c, input logic [15:0] r, input logic [15:0] rm,
                              input logic o, input logic [3:0] d, input logic w,
                              input int n, input logic [15:0] d1, input logic [15:0] d2, input logic il);
    vec_t v;
    v.ctrl = c; v.res = r; v.rem = rm; v.ovf = o; v.dest = d; v.rw = w;
    v.n_wr = n; v.d1 = d1; v.d2 = d2; v.ill = il;
    return v;
  endfunction

  // Scoreboard consumer: every observed write must match the oldest expected one.
  always @(negedge clk) begin
    if (illegal_op === 1'b1) ill_cnt++;
    if (rf_we === 1'b1) begin
      we_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_write", {12'h0, rf_waddr, rf_wdata}, 32'h0);
      end else begin
        logic [19:0] e;
        e = sb.pop_front();
        check("wr_addr", {28'h0, rf_waddr}, {28'h0, e[19:16]});
        check("wr_data", {16'h0, rf_wdata}, {16'h0, e[15:0]});
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    exp_ret = 0;
  endtask

  task automatic send(input logic [3:0] c, input logic [15:0] r, input logic [15:0] rm,
                      input logic o, input logic [3:0] d, input logic w);
    int waited = 0;
    while (in_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (in_ready !== 1'b1) check("ready_timeout", {31'h0, in_ready}, 32'h1);
    CTRL = c; ALU_Result = r; Remainder = rm; Overflow_flag = o; dest_reg = d; reg_write = w;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    exp_ret++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int b2b_we, b2b_ill;

    // ctrl res rem ovf dest rw n_wr d1 d2 ill
    vecs.push_back(mk(4'd0,  16'd1050,  16'd0,     1'b0, 4'd3,  1'b1, 1, 16'd1050,  16'd0,     1'b0));
    vecs.push_back(mk(4'd5,  16'd4,     16'd1,     1'b0, 4'd2,  1'b1, 2, 16'd4,     16'd1,     1'b0));
    vecs.push_back(mk(4'd1,  16'hFFFF,  16'h0,     1'b0, 4'd7,  1'b1, 1, 16'hFFFF,  16'd0,     1'b0));
    vecs.push_back(mk(4'd2,  16'h00F0,  16'h0,     1'b0, 4'd4,  1'b0, 0, 16'd0,     16'd0,     1'b0));
    vecs.push_back(mk(4'd4,  16'h1234,  16'hABCD,  1'b0, 4'd1,  1'b1, 2, 16'h1234,  16'hABCD,  1'b0));
    vecs.push_back(mk(4'd5,  16'd9,     16'd3,     1'b0, 4'd15, 1'b1, 2, 16'd9,     16'd3,     1'b0));
    vecs.push_back(mk(4'd9,  16'h8001,  16'h0,     1'b0, 4'd0,  1'b1, 1, 16'h8001,  16'd0,     1'b0));
    vecs.push_back(mk(4'd4,  16'h5555,  16'h6666,  1'b0, 4'd6,  1'b0, 0, 16'd0,     16'd0,     1'b0));
    vecs.push_back(mk(4'd13, 16'h7777,  16'h0,     1'b0, 4'd8,  1'b1, 0, 16'd0,     16'd0,     1'b1));
    vecs.push_back(mk(4'd6,  16'h0F00,  16'h0,     1'b1, 4'd9,  1'b1, 1, 16'h0F00,  16'd0,     1'b0));

    do_reset();
    check("rst_rf_we", {31'h0, rf_we}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_exc", {31'h0, exc}, 32'h0);
    check("rst_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);
    check("rst_illegal", {31'h0, illegal_op}, 32'h0);
    check("rst_retired", {16'h0, retired}, 32'h0);
    check("rst_in_ready", {31'h0, in_ready}, 32'h1);

    foreach (vecs[i]) begin
      if (vecs[i].n_wr >= 1) sb.push_back({vecs[i].dest, vecs[i].d1});
      if (vecs[i].n_wr == 2) sb.push_back({4'd15, vecs[i].d2});
      send(vecs[i].ctrl, vecs[i].res, vecs[i].rem, vecs[i].ovf, vecs[i].dest, vecs[i].rw);
      check($sformatf("v%0d_rf_we", i), {31'h0, rf_we}, {31'h0, (vecs[i].n_wr > 0)});
      check($sformatf("v%0d_illegal", i), {31'h0, illegal_op}, {31'h0, vecs[i].ill});
      check($sformatf("v%0d_in_ready", i), {31'h0, in_ready}, {31'h0, (vecs[i].n_wr != 2)});
      if (vecs[i].n_wr == 2) begin
        @(posedge clk); #1;
        check($sformatf("v%0d_ready_after_rem", i), {31'h0, in_ready}, 32'h1);
      end
    end
    @(posedge clk); #1;
    check("table_retired", {16'h0, retired}, exp_ret);
    check("table_ovf_sticky", {31'h0, ovf_sticky}, 32'h0);
    check("table_halted", {31'h0, halted}, 32'h0);

    // Back-to-back: adds with reg_write 1,0,1 then an illegal opcode.
    do_reset();
    b2b_we = we_cnt;
    b2b_ill = ill_cnt;
    sb.push_back({4'd1, 16'h0011});
    sb.push_back({4'd3, 16'h0033});
    send(4'd0, 16'h0011, 16'h0, 1'b0, 4'd1, 1'b1);
    check("b2b_ready", {31'h0, in_ready}, 32'h1);
    send(4'd0, 16'h0022, 16'h0, 1'b0, 4'd2, 1'b0);
    send(4'd0, 16'h0033, 16'h0, 1'b0, 4'd3, 1'b1);
    send(4'd12, 16'h0044, 16'h0, 1'b0, 4'd4, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("b2b_we_pulses", we_cnt - b2b_we, 32'd2);
    check("b2b_illegal_pulses", ill_cnt - b2b_ill, 32'd1);
    check("b2b_retired", {16'h0, retired}, 32'd4);

    // Overflowing multiply.
`ifdef OVERFLOW_TRAP_EN
    send(4'd4, 16'd28928, 16'd2, 1'b1, 4'd5, 1'b1);
    check("mulovf_rf_we", {31'h0, rf_we}, 32'h0);
    check("mulovf_exc", {31'h0, exc}, 32'h1);
    check("mulovf_halted", {31'h0, halted}, 32'h1);
    check("mulovf_in_ready", {31'h0, in_ready}, 32'h0);
    @(posedge clk); #1;
    check("mulovf_no_rem", {31'h0, rf_we}, 32'h0);
`else
    sb.push_back({4'd5, 16'd28928});
    sb.push_back({4'd15, 16'd2});
    send(4'd4, 16'd28928, 16'd2, 1'b1, 4'd5, 1'b1);
    check("mulovf_rf_we", {31'h0, rf_we}, 32'h1);
    check("mulovf_exc", {31'h0, exc}, 32'h0);
    check("mulovf_halted", {31'h0, halted}, 32'h0);
    @(posedge clk); #1;
    check("mulovf_rem_we", {31'h0, rf_we}, 32'h1);
`endif
    check("mulovf_sticky", {31'h0, ovf_sticky}, 32'h1);
    check("mulovf_retired", {16'h0, retired}, 32'd5);

    // Halt, then an add offered with in_valid held must not be accepted.
    do_reset();
    send(4'd10, 16'h0, 16'h0, 1'b0, 4'd3, 1'b1);
    check("halt_halted", {31'h0, halted}, 32'h1);
    check("halt_in_ready", {31'h0, in_ready}, 32'h0);
    check("halt_rf_we", {31'h0, rf_we}, 32'h0);
    CTRL = 4'd0; ALU_Result = 16'h0BAD; dest_reg = 4'd3; reg_write = 1'b1; Overflow_flag = 1'b0;
    in_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("halt_hold_retired", {16'h0, retired}, 32'd1);
    check("halt_hold_ready", {31'h0, in_ready}, 32'h0);
    do_reset();
    check("halt_rst_halted", {31'h0, halted}, 32'h0);
    check("halt_rst_retired", {16'h0, retired}, 32'h0);
    check("halt_rst_in_ready", {31'h0, in_ready}, 32'h1);

    // Reset in the cycle after a divide is accepted: Rd write only.
    sb.push_back({4'd2, 16'd4});
    send(4'd5, 16'd4, 16'd1, 1'b0, 4'd2, 1'b1);
    check("rstmid_first_we", {31'h0, rf_we}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rstmid_rf_we", {31'h0, rf_we}, 32'h0);
    check("rstmid_retired", {16'h0, retired}, 32'h0);
    check("rstmid_in_ready", {31'h0, in_ready}, 32'h1);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drain", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
